// File: rtl/dror_pkg.sv
// Shared definitions for the DROR point-cloud loader.
//
// Contents:
//   state_t            loader FSM states
//   HDR_SIZE_WORD      x BRAM word that holds the frame size
//   HDR_FLAG_WORD      y BRAM word that holds the start flag;
//                      z BRAM word that carries the filter's done marker
//   DATA_BASE_WORD     first word of packed point data
//   DONE_MAGIC_DEFAULT marker the filter writes when it finishes a frame
//   word_to_byte_addr  converts a word index into a BRAM byte address
package dror_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HDR_SIZE,
    HDR_START,
    POLL_ADDR,
    POLL_WAIT,
    POLL_CHK,
    CLEAR_DONE
  } state_t;

  localparam logic [31:0] HDR_SIZE_WORD      = 32'd0;
  localparam logic [31:0] HDR_FLAG_WORD      = 32'd0;
  localparam logic [31:0] DATA_BASE_WORD     = 32'd1;
  localparam logic [31:0] DONE_MAGIC_DEFAULT = 32'h0000_0FFF;

  function automatic logic [31:0] word_to_byte_addr(input logic [31:0] word,
                                                     input int shift);
    return word << shift;
  endfunction

endpackage

// File: rtl/point_packer.sv
// Packs successive N-bit coordinates of one axis into BUS_SIZE-bit BRAM words.
//
// Ports:
//   clock, reset  system clock, asynchronous active-high reset
//   store         the current beat is stored (accepted and within capacity)
//   last          the current beat is the last of the frame
//   beat_idx      0-based index of the current beat within the frame
//   coord         coordinate of the current beat
//   word_data     word to write when wr_strobe is high
//   wr_strobe     a word is complete this cycle
//   word_idx      BRAM word index for word_data
module point_packer
  import dror_pkg::*;
#(
  parameter int N        = 16,
  parameter int BUS_SIZE = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                store,
  input  logic                last,
  input  logic [15:0]         beat_idx,
  input  logic [N-1:0]        coord,
  output logic [BUS_SIZE-1:0] word_data,
  output logic                wr_strobe,
  output logic [31:0]         word_idx
);

  logic [N-1:0] hold;

  // Even beats park their coordinate until the odd partner arrives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold <= '0;
    end else if (store && !beat_idx[0]) begin
      hold <= coord;
    end
  end

  // Odd beats complete a pair with the newer point in the upper half; a
  // trailing even beat is written alone with the upper half zero.
  always_comb begin
    wr_strobe = store && (beat_idx[0] || last);
    if (beat_idx[0]) begin
      word_data = BUS_SIZE'({coord, hold});
    end else begin
      word_data = BUS_SIZE'(coord);
    end
    word_idx = DATA_BASE_WORD + 32'(beat_idx[15:1]);
  end

endmodule

// File: rtl/point_cloud_loader.sv
// Streams (x,y,z) points into the DROR filter's x/y/z BRAMs through port B,
// writes the frame header (size, then start flag) and waits for the filter
// to post its done marker in z word 0, which it then clears.
//
// Ports:
//   clock, reset              system clock, asynchronous active-high reset
//   s_valid/s_ready           point beat handshake
//   s_x, s_y, s_z, s_last     point coordinates and end-of-frame marker
//   addr_*, din_*, we_*, en_* registered BRAM port B controls per axis
//   dout_z                    z BRAM read data (one cycle latency)
//   busy                      loader is not idle
//   frame_done                one-cycle pulse when the done marker is consumed
//   point_count               points stored in the current or last frame
//   overflow                  sticky: a frame exceeded MAX_POINTS
//   timeout                   sticky: the filter never reported done
module point_cloud_loader
  import dror_pkg::*;
#(
  parameter int                  N          = 16,
  parameter int                  BUS_SIZE   = 32,
  parameter int                  BRAM_SHIFT = 2,
  parameter int                  MAX_POINTS = 4096,
  parameter logic [BUS_SIZE-1:0] DONE_MAGIC = BUS_SIZE'(DONE_MAGIC_DEFAULT),
  parameter int                  TIMEOUT    = 2**20
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [N-1:0]        s_x,
  input  logic [N-1:0]        s_y,
  input  logic [N-1:0]        s_z,
  input  logic                s_last,
  output logic [31:0]         addr_x,
  output logic [31:0]         addr_y,
  output logic [31:0]         addr_z,
  output logic [BUS_SIZE-1:0] din_x,
  output logic [BUS_SIZE-1:0] din_y,
  output logic [BUS_SIZE-1:0] din_z,
  output logic [3:0]          we_x,
  output logic [3:0]          we_y,
  output logic [3:0]          we_z,
  output logic                en_x,
  output logic                en_y,
  output logic                en_z,
  input  logic [BUS_SIZE-1:0] dout_z,
  output logic                busy,
  output logic                frame_done,
  output logic [15:0]         point_count,
  output logic                overflow,
  output logic                timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t              state, next_state;
  logic [TW-1:0]       poll_timer;
  logic                accept, stored, set_timeout;
  logic [15:0]         beat_idx;

  logic [BUS_SIZE-1:0] word_x, word_y, word_z;
  logic                wr_x, wr_y, wr_z;
  logic [31:0]         idx_x, idx_y, idx_z;

  logic [31:0]         nx_addr_x, nx_addr_y, nx_addr_z;
  logic [BUS_SIZE-1:0] nx_din_x, nx_din_y, nx_din_z;
  logic [3:0]          nx_we_x, nx_we_y, nx_we_z;
  logic                nx_en_x, nx_en_y, nx_en_z;
  logic                nx_frame_done;

  // In IDLE the incoming beat is the first of a new frame, so its index is 0
  // regardless of what the previous frame left in point_count.
  always_comb begin
    accept   = s_valid && s_ready;
    beat_idx = (state == IDLE) ? 16'd0 : point_count;
    stored   = accept && (int'(beat_idx) < MAX_POINTS);
  end

  assign busy = (state != IDLE);

  point_packer #(.N(N), .BUS_SIZE(BUS_SIZE)) u_pack_x (
    .clock(clock), .reset(reset), .store(stored), .last(s_last),
    .beat_idx(beat_idx), .coord(s_x),
    .word_data(word_x), .wr_strobe(wr_x), .word_idx(idx_x)
  );

  point_packer #(.N(N), .BUS_SIZE(BUS_SIZE)) u_pack_y (
    .clock(clock), .reset(reset), .store(stored), .last(s_last),
    .beat_idx(beat_idx), .coord(s_y),
    .word_data(word_y), .wr_strobe(wr_y), .word_idx(idx_y)
  );

  point_packer #(.N(N), .BUS_SIZE(BUS_SIZE)) u_pack_z (
    .clock(clock), .reset(reset), .store(stored), .last(s_last),
    .beat_idx(beat_idx), .coord(s_z),
    .word_data(word_z), .wr_strobe(wr_z), .word_idx(idx_z)
  );

  // Next-state and next BRAM command. The command is registered onto the
  // ports, so each state's access appears on the BRAM one cycle later.
  always_comb begin
    next_state    = state;
    nx_addr_x     = '0;
    nx_addr_y     = '0;
    nx_addr_z     = '0;
    nx_din_x      = '0;
    nx_din_y      = '0;
    nx_din_z      = '0;
    nx_we_x       = 4'h0;
    nx_we_y       = 4'h0;
    nx_we_z       = 4'h0;
    nx_en_x       = 1'b0;
    nx_en_y       = 1'b0;
    nx_en_z       = 1'b0;
    nx_frame_done = 1'b0;
    set_timeout   = 1'b0;

    unique case (state)
      IDLE, LOAD: begin
        if (wr_x) begin
          nx_addr_x = word_to_byte_addr(idx_x, BRAM_SHIFT);
          nx_din_x  = word_x;
          nx_we_x   = 4'hF;
          nx_en_x   = 1'b1;
        end
        if (wr_y) begin
          nx_addr_y = word_to_byte_addr(idx_y, BRAM_SHIFT);
          nx_din_y  = word_y;
          nx_we_y   = 4'hF;
          nx_en_y   = 1'b1;
        end
        if (wr_z) begin
          nx_addr_z = word_to_byte_addr(idx_z, BRAM_SHIFT);
          nx_din_z  = word_z;
          nx_we_z   = 4'hF;
          nx_en_z   = 1'b1;
        end
        if (accept) begin
          next_state = s_last ? HDR_SIZE : LOAD;
        end
      end
      HDR_SIZE: begin
        nx_addr_x  = word_to_byte_addr(HDR_SIZE_WORD, BRAM_SHIFT);
        nx_din_x   = BUS_SIZE'(point_count);
        nx_we_x    = 4'hF;
        nx_en_x    = 1'b1;
        next_state = HDR_START;
      end
      HDR_START: begin
        nx_addr_y  = word_to_byte_addr(HDR_FLAG_WORD, BRAM_SHIFT);
        nx_din_y   = BUS_SIZE'(1);
        nx_we_y    = 4'hF;
        nx_en_y    = 1'b1;
        next_state = POLL_ADDR;
      end
      POLL_ADDR: begin
        nx_addr_z  = word_to_byte_addr(HDR_FLAG_WORD, BRAM_SHIFT);
        nx_en_z    = 1'b1;
        next_state = POLL_WAIT;
      end
      POLL_WAIT: begin
        next_state = POLL_CHK;
      end
      POLL_CHK: begin
        if (dout_z == DONE_MAGIC) begin
          next_state = CLEAR_DONE;
        end else if (poll_timer == TW'(TIMEOUT - 1)) begin
          set_timeout = 1'b1;
          next_state  = IDLE;
        end else begin
          next_state = POLL_ADDR;
        end
      end
      CLEAR_DONE: begin
        nx_addr_z     = word_to_byte_addr(HDR_FLAG_WORD, BRAM_SHIFT);
        nx_din_z      = '0;
        nx_we_z       = 4'hF;
        nx_en_z       = 1'b1;
        nx_frame_done = 1'b1;
        next_state    = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // s_ready is registered from next_state so it is low during reset and
  // never reopens in the cycle that the last beat is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_ready    <= 1'b0;
      addr_x     <= '0;
      addr_y     <= '0;
      addr_z     <= '0;
      din_x      <= '0;
      din_y      <= '0;
      din_z      <= '0;
      we_x       <= 4'h0;
      we_y       <= 4'h0;
      we_z       <= 4'h0;
      en_x       <= 1'b0;
      en_y       <= 1'b0;
      en_z       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      s_ready    <= (next_state == IDLE) || (next_state == LOAD);
      addr_x     <= nx_addr_x;
      addr_y     <= nx_addr_y;
      addr_z     <= nx_addr_z;
      din_x      <= nx_din_x;
      din_y      <= nx_din_y;
      din_z      <= nx_din_z;
      we_x       <= nx_we_x;
      we_y       <= nx_we_y;
      we_z       <= nx_we_z;
      en_x       <= nx_en_x;
      en_y       <= nx_en_y;
      en_z       <= nx_en_z;
      frame_done <= nx_frame_done;
    end
  end

  // The first beat of a frame restarts the count and clears overflow; beats
  // beyond capacity are swallowed, so the count saturates at MAX_POINTS.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      point_count <= '0;
      overflow    <= 1'b0;
    end else if (accept) begin
      point_count <= stored ? (beat_idx + 16'd1) : beat_idx;
      overflow    <= ((state != IDLE) && overflow) || !stored;
    end
  end

  // Counts unsuccessful done checks; restarted as each header goes out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      poll_timer <= '0;
      timeout    <= 1'b0;
    end else begin
      if (state == HDR_START) begin
        poll_timer <= '0;
      end else if ((state == POLL_CHK) && (next_state == POLL_ADDR)) begin
        poll_timer <= poll_timer + TW'(1);
      end
      if (set_timeout) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_point_cloud_loader.sv
// Self-checking bench for point_cloud_loader. The main instance has a
// capacity of 4 points; a second instance with a short poll limit and a
// filter that never finishes exercises the timeout path.
module tb_point_cloud_loader;

  typedef struct {
    int          bram;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        s_valid, s_valid_t, s_last;
  logic [15:0] s_x, s_y, s_z;

  logic        s_ready, busy, frame_done, overflow, timeout;
  logic [31:0] addr_x, addr_y, addr_z, din_x, din_y, din_z;
  logic [3:0]  we_x, we_y, we_z;
  logic        en_x, en_y, en_z;
  logic [15:0] point_count;
  logic [31:0] dout_z = 32'h0;

  logic        s_ready_t, busy_t, frame_done_t, overflow_t, timeout_t;
  logic [31:0] addr_x_t, addr_y_t, addr_z_t, din_x_t, din_y_t, din_z_t;
  logic [3:0]  we_x_t, we_y_t, we_z_t;
  logic        en_x_t, en_y_t, en_z_t;
  logic [15:0] point_count_t;
  logic [31:0] dout_z_t;

  int asserts = 0;
  int failures = 0;
  wr_t exp_q[$];
  wr_t obs_q[$];
  int done_pulses = 0;
  int poll_reads = 0;
  int hs_count = 0;
  int rd_count = 0;
  int done_at = 0;

  always #5 clock = ~clock;

  assign dout_z_t = 32'h0;

  point_cloud_loader #(.MAX_POINTS(4), .TIMEOUT(64)) dut (
    .clock(clock), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_x(s_x), .s_y(s_y), .s_z(s_z), .s_last(s_last),
    .addr_x(addr_x), .addr_y(addr_y), .addr_z(addr_z),
    .din_x(din_x), .din_y(din_y), .din_z(din_z),
    .we_x(we_x), .we_y(we_y), .we_z(we_z),
    .en_x(en_x), .en_y(en_y), .en_z(en_z),
    .dout_z(dout_z), .busy(busy), .frame_done(frame_done),
    .point_count(point_count), .overflow(overflow), .timeout(timeout)
  );

  point_cloud_loader #(.TIMEOUT(8)) dut_t (
    .clock(clock), .reset(reset),
    .s_valid(s_valid_t), .s_ready(s_ready_t),
    .s_x(s_x), .s_y(s_y), .s_z(s_z), .s_last(s_last),
    .addr_x(addr_x_t), .addr_y(addr_y_t), .addr_z(addr_z_t),
    .din_x(din_x_t), .din_y(din_y_t), .din_z(din_z_t),
    .we_x(we_x_t), .we_y(we_y_t), .we_z(we_z_t),
    .en_x(en_x_t), .en_y(en_y_t), .en_z(en_z_t),
    .dout_z(dout_z_t), .busy(busy_t), .frame_done(frame_done_t),
    .point_count(point_count_t), .overflow(overflow_t), .timeout(timeout_t)
  );

  // Collects every BRAM write of the main instance in x, y, z order.
  always @(negedge clock) begin
    if (we_x != 4'h0) obs_q.push_back('{0, addr_x, din_x});
    if (we_y != 4'h0) obs_q.push_back('{1, addr_y, din_y});
    if (we_z != 4'h0) obs_q.push_back('{2, addr_z, din_z});
    if (frame_done) done_pulses <= done_pulses + 1;
    if (en_z && we_z == 4'h0) poll_reads <= poll_reads + 1;
  end

  // Handshake counter and the filter's view of z word 0: reads return zero
  // until done_at reads have been served, then the done marker.
  always @(posedge clock) begin
    if (s_valid && s_ready) hs_count <= hs_count + 1;
    if (en_z && we_z == 4'h0) begin
      rd_count <= rd_count + 1;
      dout_z   <= (rd_count >= done_at) ? 32'h0000_0FFF : 32'h0;
    end
  end

  task automatic push_triple(input logic [31:0] addr, input logic [31:0] wx,
                             input logic [31:0] wy, input logic [31:0] wz);
    exp_q.push_back('{0, addr, wx});
    exp_q.push_back('{1, addr, wy});
    exp_q.push_back('{2, addr, wz});
  endtask

  task automatic push_header(input logic [31:0] size);
    exp_q.push_back('{0, 32'h0, size});
    exp_q.push_back('{1, 32'h0, 32'h1});
    exp_q.push_back('{2, 32'h0, 32'h0});
  endtask

  // Called at a negedge; returns at the negedge after the beat is taken.
  task automatic send_beat(input logic [15:0] x, input logic last);
    int guard;
    guard = 0;
    s_x = x; s_y = x + 16'h10; s_z = x + 16'h20; s_last = last;
    s_valid = 1'b1;
    while (!s_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (!s_ready) begin
      asserts++; failures++;
      $display("[TB] FAIL send_beat ready: got 0 want 1");
    end
    @(negedge clock);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_frame_done(input string name);
    int guard;
    guard = 0;
    while (!frame_done && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    asserts++;
    if (!frame_done) begin
      failures++;
      $display("[TB] FAIL %s frame_done: got 0 want 1 within 300 cycles", name);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    #1;
    asserts++;
    if ({s_ready, busy, frame_done, overflow, timeout} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset flags: got %b want 00000",
               {s_ready, busy, frame_done, overflow, timeout});
    end
    asserts++;
    if ({we_x, we_y, we_z, en_x, en_y, en_z} !== 15'h0) begin
      failures++;
      $display("[TB] FAIL reset bram ctl: got %h want 0", {we_x, we_y, we_z, en_x, en_y, en_z});
    end
    asserts++;
    if ({addr_x, din_x, point_count} !== 80'h0) begin
      failures++;
      $display("[TB] FAIL reset addr/data/count: got %h want 0", {addr_x, din_x, point_count});
    end
    asserts++;
    if ({s_ready_t, busy_t, timeout_t, point_count_t} !== 19'h0) begin
      failures++;
      $display("[TB] FAIL reset second instance: got %h want 0",
               {s_ready_t, busy_t, timeout_t, point_count_t});
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_four_point();
    wr_t e, o;
    done_at = 0;
    push_triple(32'h4, 32'h0002_0001, 32'h0012_0011, 32'h0022_0021);
    push_triple(32'h8, 32'h0004_0003, 32'h0014_0013, 32'h0024_0023);
    push_header(32'd4);
    send_beat(16'h1, 1'b0);
    send_beat(16'h2, 1'b0);
    send_beat(16'h3, 1'b0);
    send_beat(16'h4, 1'b1);
    @(negedge clock);
    asserts++;
    if (we_x !== 4'hF || addr_x !== 32'h0 || din_x !== 32'h4 || we_y !== 4'h0) begin
      failures++;
      $display("[TB] FAIL four_point size word: got we_x=%h addr=%h din=%h we_y=%h want F 0 4 0",
               we_x, addr_x, din_x, we_y);
    end
    @(negedge clock);
    asserts++;
    if (we_y !== 4'hF || addr_y !== 32'h0 || din_y !== 32'h1 || we_x !== 4'h0) begin
      failures++;
      $display("[TB] FAIL four_point start flag: got we_y=%h addr=%h din=%h we_x=%h want F 0 1 0",
               we_y, addr_y, din_y, we_x);
    end
    wait_frame_done("four_point");
    asserts++;
    if (point_count !== 16'd4) begin
      failures++;
      $display("[TB] FAIL four_point count: got %0d want 4", point_count);
    end
    asserts++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("[TB] FAIL four_point writes: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); asserts++;
      if (o.bram !== e.bram || o.addr !== e.addr || o.data !== e.data) begin
        failures++;
        $display("[TB] FAIL four_point write: got b%0d %h=%h want b%0d %h=%h",
                 o.bram, o.addr, o.data, e.bram, e.addr, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_three_point();
    wr_t e, o;
    done_at = 0;
    push_triple(32'h4, 32'h000B_000A, 32'h001B_001A, 32'h002B_002A);
    push_triple(32'h8, 32'h0000_000C, 32'h0000_001C, 32'h0000_002C);
    push_header(32'd3);
    send_beat(16'hA, 1'b0);
    send_beat(16'hB, 1'b0);
    send_beat(16'hC, 1'b1);
    wait_frame_done("three_point");
    asserts++;
    if (point_count !== 16'd3) begin
      failures++;
      $display("[TB] FAIL three_point count: got %0d want 3", point_count);
    end
    asserts++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("[TB] FAIL three_point writes: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); asserts++;
      if (o.bram !== e.bram || o.addr !== e.addr || o.data !== e.data) begin
        failures++;
        $display("[TB] FAIL three_point write: got b%0d %h=%h want b%0d %h=%h",
                 o.bram, o.addr, o.data, e.bram, e.addr, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_poll_wait();
    wr_t e, o;
    int ready_bad, busy_bad, guard, pulses0, reads0;
    ready_bad = 0; busy_bad = 0; guard = 0;
    pulses0 = done_pulses; reads0 = poll_reads;
    done_at = rd_count + 10;
    push_triple(32'h4, 32'h0006_0005, 32'h0016_0015, 32'h0026_0025);
    push_header(32'd2);
    send_beat(16'h5, 1'b0);
    send_beat(16'h6, 1'b1);
    while (!frame_done && guard < 300) begin
      if (s_ready) ready_bad++;
      if (!busy) busy_bad++;
      @(negedge clock);
      guard++;
    end
    asserts++;
    if (!frame_done || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL poll_wait end: got done=%b busy=%b want 1 0", frame_done, busy);
    end
    asserts++;
    if (ready_bad != 0 || busy_bad != 0) begin
      failures++;
      $display("[TB] FAIL poll_wait hold: got ready_cycles=%0d idle_cycles=%0d want 0 0",
               ready_bad, busy_bad);
    end
    repeat (2) @(negedge clock);
    asserts++;
    if (poll_reads - reads0 != 11) begin
      failures++;
      $display("[TB] FAIL poll_wait reads: got %0d want 11", poll_reads - reads0);
    end
    asserts++;
    if (done_pulses - pulses0 != 1 || timeout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL poll_wait pulses/timeout: got %0d %b want 1 0",
               done_pulses - pulses0, timeout);
    end
    asserts++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("[TB] FAIL poll_wait writes: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); asserts++;
      if (o.bram !== e.bram || o.addr !== e.addr || o.data !== e.data) begin
        failures++;
        $display("[TB] FAIL poll_wait write: got b%0d %h=%h want b%0d %h=%h",
                 o.bram, o.addr, o.data, e.bram, e.addr, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_overflow();
    wr_t e, o;
    int hs0;
    hs0 = hs_count;
    done_at = 0;
    push_triple(32'h4, 32'h0002_0001, 32'h0012_0011, 32'h0022_0021);
    push_triple(32'h8, 32'h0004_0003, 32'h0014_0013, 32'h0024_0023);
    push_header(32'd4);
    for (int i = 1; i <= 6; i++) send_beat(16'(i), i == 6);
    wait_frame_done("overflow");
    asserts++;
    if (overflow !== 1'b1 || point_count !== 16'd4) begin
      failures++;
      $display("[TB] FAIL overflow flag/count: got %b %0d want 1 4", overflow, point_count);
    end
    asserts++;
    if (hs_count - hs0 != 6) begin
      failures++;
      $display("[TB] FAIL overflow beats accepted: got %0d want 6", hs_count - hs0);
    end
    asserts++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("[TB] FAIL overflow writes: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); asserts++;
      if (o.bram !== e.bram || o.addr !== e.addr || o.data !== e.data) begin
        failures++;
        $display("[TB] FAIL overflow write: got b%0d %h=%h want b%0d %h=%h",
                 o.bram, o.addr, o.data, e.bram, e.addr, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_load();
    wr_t e, o;
    done_at = 0;
    push_triple(32'h4, 32'h0008_0007, 32'h0018_0017, 32'h0028_0027);
    send_beat(16'h7, 1'b0);
    send_beat(16'h8, 1'b0);
    send_beat(16'h9, 1'b0);
    #2 reset = 1'b1;
    #1;
    asserts++;
    if ({s_ready, busy, frame_done, overflow, point_count} !== 20'h0) begin
      failures++;
      $display("[TB] FAIL mid_reset flags: got %h want 0",
               {s_ready, busy, frame_done, overflow, point_count});
    end
    asserts++;
    if ({we_x, we_y, we_z, en_x, en_y, en_z, addr_x, din_y} !== 79'h0) begin
      failures++;
      $display("[TB] FAIL mid_reset bram ports: got %h want 0",
               {we_x, we_y, we_z, en_x, en_y, en_z, addr_x, din_y});
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    push_triple(32'h4, 32'h0032_0031, 32'h0042_0041, 32'h0052_0051);
    push_header(32'd2);
    send_beat(16'h31, 1'b0);
    send_beat(16'h32, 1'b1);
    wait_frame_done("mid_reset");
    asserts++;
    if (point_count !== 16'd2) begin
      failures++;
      $display("[TB] FAIL mid_reset count: got %0d want 2", point_count);
    end
    asserts++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("[TB] FAIL mid_reset writes: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); asserts++;
      if (o.bram !== e.bram || o.addr !== e.addr || o.data !== e.data) begin
        failures++;
        $display("[TB] FAIL mid_reset write: got b%0d %h=%h want b%0d %h=%h",
                 o.bram, o.addr, o.data, e.bram, e.addr, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_timeout();
    int guard, reads, dones;
    guard = 0; reads = 0; dones = 0;
    s_x = 16'h55; s_y = 16'h65; s_z = 16'h75; s_last = 1'b1;
    s_valid_t = 1'b1;
    while (!s_ready_t && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    @(negedge clock);
    s_valid_t = 1'b0;
    s_last    = 1'b0;
    guard = 0;
    while (!timeout_t && guard < 200) begin
      if (en_z_t && we_z_t == 4'h0) reads++;
      if (frame_done_t) dones++;
      @(negedge clock);
      guard++;
    end
    repeat (4) begin
      @(negedge clock);
      if (en_z_t && we_z_t == 4'h0) reads++;
      if (frame_done_t) dones++;
    end
    asserts++;
    if (timeout_t !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timeout flag: got %b want 1", timeout_t);
    end
    asserts++;
    if (reads != 8) begin
      failures++;
      $display("[TB] FAIL timeout polls: got %0d want 8", reads);
    end
    asserts++;
    if (dones != 0 || busy_t !== 1'b0 || s_ready_t !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timeout idle: got dones=%0d busy=%b ready=%b want 0 0 1",
               dones, busy_t, s_ready_t);
    end
    asserts++;
    if (point_count_t !== 16'd1) begin
      failures++;
      $display("[TB] FAIL timeout count: got %0d want 1", point_count_t);
    end
  endtask

  initial begin
    reset = 1'b1;
    s_valid = 1'b0; s_valid_t = 1'b0; s_last = 1'b0;
    s_x = 16'h0; s_y = 16'h0; s_z = 16'h0;
    test_reset();
    test_four_point();
    test_three_point();
    test_poll_wait();
    test_overflow();
    test_reset_mid_load();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
